// File: rtl/reg_demux_timeout.sv
// Register-bus demultiplexer: routes one upstream request to the first matching
// slave port and returns an error response on a decode miss or a slave timeout.
module reg_demux_timeout #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_PORTS      = 4,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hBADCAB1E
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  input  logic                              in_write_i,
  input  logic [ADDR_WIDTH-1:0]             in_addr_i,
  input  logic [DATA_WIDTH-1:0]             in_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]           in_wstrb_i,
  output logic                              in_ready_o,
  output logic [DATA_WIDTH-1:0]             in_rdata_o,
  output logic                              in_error_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_base_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_mask_i,
  output logic [NUM_PORTS-1:0]              out_valid_o,
  output logic                              out_write_o,
  output logic [ADDR_WIDTH-1:0]             out_addr_o,
  output logic [DATA_WIDTH-1:0]             out_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           out_wstrb_o,
  input  logic [NUM_PORTS-1:0]              out_ready_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   out_rdata_i,
  input  logic [NUM_PORTS-1:0]              out_error_i,
  output logic                              timeout_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0]  CNT_SAT  = {CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [SEL_WIDTH-1:0]   sel;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   hit;
  logic [SEL_WIDTH-1:0]   hit_idx;
  logic                   sel_ready;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   sel_error;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [SEL_WIDTH-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      v[i] = (idx == SEL_WIDTH'(i));
    end
    return v;
  endfunction

  // Address decode; scanning from the top lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((in_addr_i & addr_mask_i[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (addr_base_i[i*ADDR_WIDTH +: ADDR_WIDTH] & addr_mask_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = SEL_WIDTH'(i);
      end else begin
        hit     = hit;
        hit_idx = hit_idx;
      end
    end
  end

  // Response mux for the latched port; other ports' ready/rdata/error never reach the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    sel_error = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        sel_ready = out_ready_i[i];
        sel_rdata = out_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_error = out_error_i[i];
      end else begin
        sel_ready = sel_ready;
        sel_rdata = sel_rdata;
        sel_error = sel_error;
      end
    end
  end

  // Transaction FSM with all upstream and downstream outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      in_ready_o  <= 1'b0;
      in_rdata_o  <= '0;
      in_error_o  <= 1'b0;
      out_valid_o <= '0;
      out_write_o <= 1'b0;
      out_addr_o  <= '0;
      out_wdata_o <= '0;
      out_wstrb_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_o <= 1'b0;
          timeout_o  <= 1'b0;
          if (in_valid_i && hit) begin
            sel         <= hit_idx;
            cnt         <= '0;
            out_write_o <= in_write_i;
            out_addr_o  <= in_addr_i;
            out_wdata_o <= in_wdata_i;
            out_wstrb_o <= in_wstrb_i;
            out_valid_o <= port_onehot(hit_idx);
            state       <= FWD;
          end else if (in_valid_i) begin
            in_rdata_o <= ERR_DATA;
            in_error_o <= 1'b1;
            in_ready_o <= 1'b1;
            state      <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        FWD: begin
          if (sel_ready) begin
            in_rdata_o  <= sel_rdata;
            in_error_o  <= sel_error;
            in_ready_o  <= 1'b1;
            out_valid_o <= '0;
            state       <= RESP;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            // Abort without slave handshake so a hung peripheral is isolated.
            in_rdata_o  <= ERR_DATA;
            in_error_o  <= 1'b1;
            in_ready_o  <= 1'b1;
            out_valid_o <= '0;
            timeout_o   <= 1'b1;
            state       <= RESP;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end else begin
            cnt <= cnt;
          end
        end
        RESP: begin
          in_ready_o <= 1'b0;
          timeout_o  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          in_ready_o  <= 1'b0;
          timeout_o   <= 1'b0;
          out_valid_o <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_demux_timeout.sv
// Randomised scoreboard bench for reg_demux_timeout (4 ports, timeout of 8 cycles).
module tb_reg_demux_timeout;

  localparam int NP  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hBADCAB1E;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          in_valid, in_write;
  logic [31:0]   in_addr, in_wdata;
  logic [3:0]    in_wstrb;
  logic          in_ready, in_error;
  logic [31:0]   in_rdata;
  logic [NP*32-1:0] addr_base, addr_mask;
  logic [NP-1:0] out_valid;
  logic          out_write;
  logic [31:0]   out_addr, out_wdata;
  logic [3:0]    out_wstrb;
  logic [NP-1:0] out_ready;
  logic [NP*32-1:0] out_rdata;
  logic [NP-1:0] out_error;
  logic          timeout;

  reg_demux_timeout #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO),
                      .ERR_RDATA(32'hBADCAB1E)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid), .in_write_i(in_write), .in_addr_i(in_addr),
    .in_wdata_i(in_wdata), .in_wstrb_i(in_wstrb),
    .in_ready_o(in_ready), .in_rdata_o(in_rdata), .in_error_o(in_error),
    .addr_base_i(addr_base), .addr_mask_i(addr_mask),
    .out_valid_o(out_valid), .out_write_o(out_write), .out_addr_o(out_addr),
    .out_wdata_o(out_wdata), .out_wstrb_o(out_wstrb),
    .out_ready_i(out_ready), .out_rdata_i(out_rdata), .out_error_i(out_error),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  strb;
    logic        err, tmo;
    int          port, vcyc, lat, issue;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0, fails = 0;
  int          cyc = 0;
  int          cur_delay = 0;
  int          age = 0;
  bit          ignore_mon = 1'b0;
  logic [31:0] base_tab [NP] = '{32'h1000, 32'h2000, 32'h3000, 32'h1000};
  logic [31:0] mask_tab [NP] = '{32'hF000, 32'hF000, 32'hF000, 32'h9000};
  logic [31:0] rdata_tab[NP];
  logic        err_tab  [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode: first rule (lowest index) whose masked bits agree.
  function automatic int ref_decode(input logic [31:0] a);
    for (int p = 0; p < NP; p++) begin
      if ((a & mask_tab[p]) == (base_tab[p] & mask_tab[p])) return p;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Slave model: selected port raises ready after cur_delay waiting cycles; others toggle randomly.
  always @(posedge clk) begin
    #1;
    if (out_valid != '0) begin
      for (int p = 0; p < NP; p++)
        out_ready[p] = out_valid[p] ? (age == cur_delay) : 1'($urandom_range(0, 1));
      age++;
    end else begin
      age = 0;
      out_ready = 4'($urandom);
    end
  end

  // Monitor: accumulate per-transaction observations, compare at the response cycle.
  int vcnt = 0, tcnt = 0;
  always @(negedge clk) begin
    if (rst_i || ignore_mon) begin
      vcnt = 0;
      tcnt = 0;
    end else begin
      if (timeout) tcnt++;
      if (out_valid != '0) begin
        vcnt++;
        if (sb.size() == 0) begin
          check("stray_out_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          logic [3:0] eoh;
          e = sb[0];
          eoh = (e.port >= 0) ? (4'b0001 << e.port) : 4'b0000;
          check("out_valid_sel", 64'(out_valid), 64'(eoh));
          check("out_fields", {out_write, out_addr, out_wdata, out_wstrb},
                              {e.wr, e.addr, e.wdata, e.strb});
        end
      end
      if (in_ready) begin
        if (sb.size() == 0) begin
          check("stray_in_ready", 64'(in_ready), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", 64'(in_rdata), 64'(e.rdata));
          check("error", 64'(in_error), 64'(e.err));
          check("valid_cycles", 64'(vcnt), 64'(e.vcyc));
          check("timeout_pulses", 64'(tcnt), 64'(e.tmo));
          check("latency", 64'(cyc - e.issue), 64'(e.lat));
        end
        vcnt = 0;
        tcnt = 0;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int delay, input logic [31:0] force_rdata);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      rdata_tab[p] = $urandom;
      err_tab[p]   = 1'($urandom_range(0, 1));
    end
    e.port = ref_decode(addr);
    if (force_rdata != 32'd0 && e.port >= 0) begin
      rdata_tab[e.port] = force_rdata;
      err_tab[e.port]   = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      out_rdata[p*32 +: 32] = rdata_tab[p];
      out_error[p]          = err_tab[p];
    end
    cur_delay = delay;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.strb = strb; e.issue = cyc;
    if (e.port < 0) begin
      e.rdata = ERR; e.err = 1'b1; e.tmo = 1'b0; e.vcyc = 0; e.lat = 1;
    end else if (delay < TMO) begin
      e.rdata = rdata_tab[e.port]; e.err = err_tab[e.port]; e.tmo = 1'b0;
      e.vcyc = delay + 1; e.lat = delay + 2;
    end else begin
      e.rdata = ERR; e.err = 1'b1; e.tmo = 1'b1; e.vcyc = TMO; e.lat = TMO + 1;
    end
    sb.push_back(e);
    in_write = wr; in_addr = addr; in_wdata = wdata; in_wstrb = strb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL req_timeout: no in_ready after %0d cycles, expected one", n);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_write = 1'($urandom); in_addr = $urandom; in_wdata = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    in_valid = 1'b0; in_write = 1'b0; in_addr = '0; in_wdata = '0; in_wstrb = '0;
    out_ready = '0; out_rdata = '0; out_error = '0;
    for (int p = 0; p < NP; p++) begin
      addr_base[p*32 +: 32] = base_tab[p];
      addr_mask[p*32 +: 32] = mask_tab[p];
    end
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {in_ready, in_rdata, in_error, out_valid, out_write, timeout},
          64'd0);
    check("reset_fields", {out_addr, out_wdata, 28'd0, out_wstrb}, 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    do_req(1'b0, 32'h0000_2004, 32'd0, 4'hF, 0, 32'hCAFE0001);   // port1, ready at once
    do_req(1'b1, 32'h0000_1008, 32'h12345678, 4'hF, 3, 32'd0);   // port0 stalls 3 cycles
    do_req(1'b0, 32'h0000_9000, 32'd0, 4'h0, 0, 32'd0);          // decode miss
    do_req(1'b0, 32'h0000_3004, 32'd0, 4'h0, 1000, 32'd0);       // port2 hangs -> timeout
    do_req(1'b0, 32'h0000_3008, 32'd0, 4'h0, TMO - 1, 32'd0);    // ready on last allowed cycle
    do_req(1'b1, 32'h0000_1040, 32'hA5A5A5A5, 4'h3, 1, 32'd0);   // port0 and port3 both hit
    do_req(1'b0, 32'h0000_5010, 32'd0, 4'h0, 2, 32'd0);          // port3 only
    do_req(1'b1, 32'hFFFF_9ABC, 32'h0BADF00D, 4'h8, 0, 32'd0);   // miss on a write

    // Reset in the middle of a forwarded request.
    ignore_mon = 1'b1;
    @(posedge clk); #1;
    cur_delay = 1000;
    in_write = 1'b0; in_addr = 32'h0000_2010; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("fwd_before_reset", 64'(out_valid), 64'b0010);
    rst_i = 1'b1;
    #1;
    check("reset_mid_fwd", {in_ready, out_valid, timeout}, 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    ignore_mon = 1'b0;
    do_req(1'b0, 32'h0000_1100, 32'd0, 4'h0, 0, 32'h600DF00D);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 11), 32'd0);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_demux_timeout.md
Name: reg_demux_timeout

Overview:
Register-bus demultiplexer that sits directly downstream of the AXI-to-register bridge. It takes one register-bus master port and decodes the request address against NUM_PORTS base/mask rules. It forwards the request to exactly one slave port and returns that slave's response upstream. A decode miss returns an error response. A slave that does not respond within TIMEOUT_CYCLES is aborted with an error, so a hung peripheral cannot stall the bridge.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
NUM_PORTS, 4, number of slave ports (>=1)
TIMEOUT_CYCLES, 256, cycles the forwarded request may wait for slave ready; 0 disables the timeout
ERR_RDATA, 32'hBADCAB1E, rdata returned on a miss or timeout (truncated/extended to DATA_WIDTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
in_valid_i  in  1  upstream request valid
in_write_i  in  1  1=write, 0=read
in_addr_i  in  ADDR_WIDTH  request address
in_wdata_i  in  DATA_WIDTH  write data
in_wstrb_i  in  DATA_WIDTH/8  write byte strobes
in_ready_o  out  1  response valid / request done
in_rdata_o  out  DATA_WIDTH  read data
in_error_o  out  1  response error
addr_base_i  in  NUM_PORTS*ADDR_WIDTH  per-port base address (quasi-static)
addr_mask_i  in  NUM_PORTS*ADDR_WIDTH  per-port compare mask (1=bit compared)
out_valid_o  out  NUM_PORTS  per-port request valid
out_write_o, out_addr_o, out_wdata_o, out_wstrb_o  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  request fields shared by all ports
out_ready_i  in  NUM_PORTS  per-port slave ready
out_rdata_i  in  NUM_PORTS*DATA_WIDTH  per-port read data
out_error_i  in  NUM_PORTS  per-port error
timeout_o  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset: state IDLE; in_ready_o=0, in_rdata_o=0, in_error_o=0, out_valid_o=0, out_* fields=0, timeout_o=0, counter=0.
- Protocol: upstream holds in_valid_i and its fields stable until in_ready_o is high. Exactly one response cycle per request.
- Decode: port i hits when (in_addr_i & mask_i) == (base_i & mask_i). If several ports hit, the lowest index wins.
- FSM IDLE:
  - If in_valid_i and a port hits: latch the request fields and the port index, clear the counter, go to FWD.
  - If in_valid_i and no port hits: latch error=1 and rdata=ERR_RDATA, go to RESP.
- FSM FWD:
  - out_valid_o[sel]=1 from registers; all other out_valid_o bits are 0. out_* fields carry the latched request.
  - If out_ready_i[sel]: capture out_rdata_i[sel] and out_error_i[sel], deassert valid next cycle, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort, capture error=1 and rdata=ERR_RDATA, pulse timeout_o, go to RESP.
  - Else counter+1. The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.
- FSM RESP: in_ready_o=1 for exactly one cycle with the captured rdata/error, then go to IDLE. in_ready_o, in_rdata_o and in_error_o are registered.
- For writes, in_rdata_o is the captured value: slave rdata for a hit, ERR_RDATA for a miss or timeout.
- Latency:
  - Hit with immediately-ready slave: in_valid_i at cycle 0, out_valid_o at cycle 1, in_ready_o at cycle 2.
  - Miss: in_ready_o at cycle 1.
- Slave ready and the timeout limit in the same cycle: ready wins; no timeout_o.
- out_ready_i on unselected ports, or while not in FWD, is ignored.
- Abort on timeout drops out_valid_o without slave ready. This is intentional fault isolation.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values; the pending request is lost.
- No pipelining: one outstanding transaction. Requests arriving outside IDLE are not observed until IDLE.

Test Plan:
- Port map 0x1000/0xF000, 0x2000/0xF000; read 0x2004, port1 ready with rdata 0xCAFE0001 in its first valid cycle -> out_valid_o=4'b0010 at cycle 1; in_ready_o at cycle 2 with rdata 0xCAFE0001, error 0.
- Write 0x1008, wdata 0x12345678, wstrb 0xF; port0 holds ready low 3 cycles -> port0 sees write, addr, data and strobe stable for 4 cycles; single in_ready_o pulse, error 0.
- Read 0x9000 (no hit) -> no out_valid_o; in_ready_o at cycle 1 with error=1, rdata=0xBADCAB1E.
- TIMEOUT_CYCLES=8, port2 never ready -> out_valid_o[2] high exactly 8 cycles; timeout_o pulse; in_ready_o next cycle with error=1.
- TIMEOUT_CYCLES=8, port2 ready on the 8th valid cycle -> normal response; timeout_o stays 0.
- Assert rst_i during FWD -> out_valid_o=0 in the same cycle; after release, a fresh request to port0 completes normally.
- Overlapping rules (port0 and port3 both hit) -> only port0 is selected.
